// File: rtl/mmu_arbiter_if.sv
// Request, TLB and system-bus signal bundle for mmu_arbiter.
// slave is the arbiter's view; master is the view of whatever drives it.
interface mmu_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = DATA_W / 8
);
  logic [NUM_PORTS-1:0]        req_ce_i;
  logic [NUM_PORTS-1:0]        req_we_i;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata_i;
  logic [NUM_PORTS*SEL_W-1:0]  req_sel_i;
  logic [DATA_W-1:0]           rdata_o;
  logic [NUM_PORTS-1:0]        ack_o;
  logic [NUM_PORTS-1:0]        stall_req_o;

  logic                        tlb_ce_o;
  logic                        tlb_write_o;
  logic [ADDR_W-1:0]           tlb_vaddr_o;
  logic [ADDR_W-1:0]           tlb_paddr_i;
  logic [15:0]                 tlb_select_i;

  logic                        bus_ce_o;
  logic                        bus_we_o;
  logic [ADDR_W-1:0]           bus_addr_o;
  logic [DATA_W-1:0]           bus_wdata_o;
  logic [15:0]                 bus_select_o;
  logic [DATA_W-1:0]           bus_data_i;
  logic                        bus_ack_i;

  modport slave (
    input  req_ce_i, req_we_i, req_addr_i, req_wdata_i, req_sel_i,
    output rdata_o, ack_o, stall_req_o,
    output tlb_ce_o, tlb_write_o, tlb_vaddr_o,
    input  tlb_paddr_i, tlb_select_i,
    output bus_ce_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_select_o,
    input  bus_data_i, bus_ack_i
  );

  modport master (
    output req_ce_i, req_we_i, req_addr_i, req_wdata_i, req_sel_i,
    input  rdata_o, ack_o, stall_req_o,
    input  tlb_ce_o, tlb_write_o, tlb_vaddr_o,
    output tlb_paddr_i, tlb_select_i,
    input  bus_ce_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_select_o,
    output bus_data_i, bus_ack_i
  );
endinterface

// File: rtl/mmu_arbiter.sv
// N-port arbiter: TLB translation, then bus read/write with read-merge-write for partial stores.
// Define MMU_ARB_RR_EN for round-robin grant; otherwise highest index wins.
module mmu_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = DATA_W / 8
) (
  input  logic           clk,
  input  logic           rst,
  mmu_arbiter_if.slave   io
);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, XLATE, READ, WRITE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 tlb_ce_q, tlb_ce_d;
  logic                 tlb_write_q, tlb_write_d;
  logic [ADDR_W-1:0]    tlb_vaddr_q, tlb_vaddr_d;
  logic                 bus_ce_q, bus_ce_d;
  logic                 bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]    bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]    bus_wdata_q, bus_wdata_d;
  logic [15:0]          bus_select_q, bus_select_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;

  logic [NUM_PORTS-1:0] eligible;
  logic                 gnt_any;
  logic [IDX_W-1:0]     gnt_idx;
  logic [DATA_W-1:0]    merged;

`ifdef MMU_ARB_RR_EN
  logic [IDX_W-1:0]     last_q, last_d;
  int                   rr_idx;
`endif

  // A port acked this cycle is excluded so it cannot be served twice.
  assign eligible = io.req_ce_i & ~ack_q;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
`ifdef MMU_ARB_RR_EN
    rr_idx  = 0;
    // Descending distance so the nearest port after last_q wins.
    for (int k = NUM_PORTS; k >= 1; k--) begin
      rr_idx = (int'(last_q) + k) % NUM_PORTS;
      if (eligible[IDX_W'(rr_idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(rr_idx);
      end
    end
`else
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (eligible[i]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
`endif
  end

  for (genvar gi = 0; gi < SEL_W; gi++) begin : g_merge
    assign merged[gi*8 +: 8] = sel_q[gi] ? wdata_q[gi*8 +: 8] : io.bus_data_i[gi*8 +: 8];
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    tlb_ce_d     = tlb_ce_q;
    tlb_write_d  = tlb_write_q;
    tlb_vaddr_d  = tlb_vaddr_q;
    bus_ce_d     = bus_ce_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_select_d = bus_select_q;
    rdata_d      = rdata_q;
    ack_d        = '0;
`ifdef MMU_ARB_RR_EN
    last_d       = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          grant_d     = gnt_idx;
          tlb_write_d = io.req_we_i[gnt_idx];
          tlb_vaddr_d = io.req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
          wdata_d     = io.req_wdata_i[gnt_idx*DATA_W +: DATA_W];
          sel_d       = io.req_sel_i[gnt_idx*SEL_W +: SEL_W];
          tlb_ce_d    = 1'b1;
          state_d     = XLATE;
`ifdef MMU_ARB_RR_EN
          last_d      = gnt_idx;
`endif
        end
      end
      XLATE: begin
        bus_addr_d   = io.tlb_paddr_i;
        bus_select_d = io.tlb_select_i;
        bus_ce_d     = 1'b1;
        tlb_ce_d     = 1'b0;
        if (tlb_write_q && (&sel_q)) begin
          bus_we_d    = 1'b1;
          bus_wdata_d = wdata_q;
          state_d     = WRITE;
        end else begin
          bus_we_d    = 1'b0;
          state_d     = READ;
        end
      end
      READ: begin
        if (io.bus_ack_i) begin
          if (!tlb_write_q) begin
            rdata_d         = io.bus_data_i;
            ack_d[grant_q]  = 1'b1;
            bus_ce_d        = 1'b0;
            state_d         = IDLE;
          end else begin
            bus_wdata_d = merged;
            bus_we_d    = 1'b1;
            state_d     = WRITE;
          end
        end
      end
      WRITE: begin
        if (io.bus_ack_i) begin
          ack_d[grant_q] = 1'b1;
          bus_ce_d       = 1'b0;
          bus_we_d       = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      tlb_ce_q     <= 1'b0;
      tlb_write_q  <= 1'b0;
      tlb_vaddr_q  <= '0;
      bus_ce_q     <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_select_q <= '0;
      rdata_q      <= '0;
      ack_q        <= '0;
`ifdef MMU_ARB_RR_EN
      last_q       <= IDX_W'(NUM_PORTS - 1);
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      tlb_ce_q     <= tlb_ce_d;
      tlb_write_q  <= tlb_write_d;
      tlb_vaddr_q  <= tlb_vaddr_d;
      bus_ce_q     <= bus_ce_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_select_q <= bus_select_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
`ifdef MMU_ARB_RR_EN
      last_q       <= last_d;
`endif
    end
  end

  assign io.rdata_o      = rdata_q;
  assign io.ack_o        = ack_q;
  assign io.stall_req_o  = io.req_ce_i & ~ack_q;
  assign io.tlb_ce_o     = tlb_ce_q;
  assign io.tlb_write_o  = tlb_write_q;
  assign io.tlb_vaddr_o  = tlb_vaddr_q;
  assign io.bus_ce_o     = bus_ce_q;
  assign io.bus_we_o     = bus_we_q;
  assign io.bus_addr_o   = bus_addr_q;
  assign io.bus_wdata_o  = bus_wdata_q;
  assign io.bus_select_o = bus_select_q;
endmodule

// File: tb/tb_mmu_arbiter.sv
// Directed bench for mmu_arbiter: 2x32 instance for the main sequence, 4x64 for the wide partial write.
module tb_mmu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  mmu_arbiter_if #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32)) a_if ();
  mmu_arbiter_if #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(64)) b_if ();

  mmu_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32)) u_dut0 (.clk(clk), .rst(rst), .io(a_if));
  mmu_arbiter #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(64)) u_dut1 (.clk(clk), .rst(rst), .io(b_if));

  // TLB model: set the top address bit.
  assign a_if.tlb_paddr_i  = a_if.tlb_vaddr_o | 32'h8000_0000;
  assign a_if.tlb_select_i = 16'h0001;
  assign b_if.tlb_paddr_i  = b_if.tlb_vaddr_o | 32'h8000_0000;
  assign b_if.tlb_select_i = 16'h0002;

  int          wait0 = 0;
  int          txn0  = 0;
  logic [31:0] last_wdata0 = '0;
  int          txn1  = 0;
  logic [63:0] last_wdata1 = '0;

  // Bus responders: ack after waitN idle cycles of an active request.
  initial begin
    int cnt;
    cnt = 0;
    a_if.bus_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (a_if.bus_ce_o && !rst) begin
        if (cnt >= wait0) begin
          a_if.bus_ack_i = 1'b1;
          cnt = 0;
          txn0++;
          if (a_if.bus_we_o) last_wdata0 = a_if.bus_wdata_o;
        end else begin
          a_if.bus_ack_i = 1'b0;
          cnt++;
        end
      end else begin
        a_if.bus_ack_i = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin
    b_if.bus_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (b_if.bus_ce_o && !rst) begin
        b_if.bus_ack_i = 1'b1;
        txn1++;
        if (b_if.bus_we_o) last_wdata1 = b_if.bus_wdata_o;
      end else begin
        b_if.bus_ack_i = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_any0(input int budget, output int c);
    c = 0;
    do begin
      cyc();
      c++;
    end while (a_if.ack_o == 2'b00 && c < budget);
  endtask

  int c;
  int first, other;
  int t0;

  initial begin
    a_if.req_ce_i = '0; a_if.req_we_i = '0; a_if.req_addr_i = '0;
    a_if.req_wdata_i = '0; a_if.req_sel_i = '0; a_if.bus_data_i = '0;
    b_if.req_ce_i = '0; b_if.req_we_i = '0; b_if.req_addr_i = '0;
    b_if.req_wdata_i = '0; b_if.req_sel_i = '0; b_if.bus_data_i = '0;

    repeat (2) cyc();
    chk("rst_ack", 64'(a_if.ack_o), 64'h0);
    chk("rst_bus_ce", 64'(a_if.bus_ce_o), 64'h0);
    chk("rst_tlb_ce", 64'(a_if.tlb_ce_o), 64'h0);
    chk("rst_rdata", 64'(a_if.rdata_o), 64'h0);
    chk("rst_bus_addr", 64'(a_if.bus_addr_o), 64'h0);
    rst = 1'b0;
    repeat (2) cyc();

    // Single read, port 0
    a_if.req_ce_i[0] = 1'b1; a_if.req_we_i[0] = 1'b0;
    a_if.req_addr_i[0 +: 32] = 32'h0000_1000; a_if.req_sel_i[0 +: 4] = 4'hF;
    a_if.bus_data_i = 32'hDEAD_BEEF;
    #1 chk("rd_stall_c0", 64'(a_if.stall_req_o[0]), 64'h1);
    cyc();
    chk("rd_tlb_ce_c1", 64'(a_if.tlb_ce_o), 64'h1);
    chk("rd_tlb_vaddr", 64'(a_if.tlb_vaddr_o), 64'h1000);
    chk("rd_stall_c1", 64'(a_if.stall_req_o[0]), 64'h1);
    cyc();
    chk("rd_bus_ce_c2", 64'(a_if.bus_ce_o), 64'h1);
    chk("rd_bus_we_c2", 64'(a_if.bus_we_o), 64'h0);
    chk("rd_bus_addr", 64'(a_if.bus_addr_o), 64'h8000_1000);
    chk("rd_bus_sel", 64'(a_if.bus_select_o), 64'h0001);
    chk("rd_stall_c2", 64'(a_if.stall_req_o[0]), 64'h1);
    cyc();
    chk("rd_ack_c3", 64'(a_if.ack_o), 64'h1);
    chk("rd_rdata", 64'(a_if.rdata_o), 64'hDEAD_BEEF);
    chk("rd_stall_c3", 64'(a_if.stall_req_o[0]), 64'h0);
    a_if.req_ce_i[0] = 1'b0;
    cyc();
    chk("rd_ack_pulse", 64'(a_if.ack_o), 64'h0);

    // Partial write, port 1, sel=0001
    t0 = txn0;
    a_if.req_ce_i[1] = 1'b1; a_if.req_we_i[1] = 1'b1;
    a_if.req_addr_i[32 +: 32] = 32'h0000_2000;
    a_if.req_wdata_i[32 +: 32] = 32'h0000_00AA; a_if.req_sel_i[4 +: 4] = 4'h1;
    a_if.bus_data_i = 32'h1122_3344;
    wait_any0(20, c);
    chk("pw_latency", 64'(c), 64'd4);
    chk("pw_ack", 64'(a_if.ack_o), 64'h2);
    chk("pw_wdata", 64'(last_wdata0), 64'h1122_33AA);
    chk("pw_txns", 64'(txn0 - t0), 64'd2);
    a_if.req_ce_i[1] = 1'b0;
    cyc();
    chk("pw_ack_pulse", 64'(a_if.ack_o), 64'h0);

    // Contention: both ports read in the same cycle
`ifdef MMU_ARB_RR_EN
    first = 0;
`else
    first = 1;
`endif
    other = 1 - first;
    a_if.req_we_i = 2'b00;
    a_if.req_addr_i[0 +: 32] = 32'h0000_3000;
    a_if.req_addr_i[32 +: 32] = 32'h0000_4000;
    a_if.req_sel_i = 8'hFF;
    a_if.bus_data_i = 32'h55AA_55AA;
    a_if.req_ce_i = 2'b11;
    wait_any0(20, c);
    chk("ct_first_ack", 64'(a_if.ack_o), 64'(1 << first));
    chk("ct_first_lat", 64'(c), 64'd3);
    a_if.req_ce_i[first] = 1'b0;
    cyc();
    chk("ct_second_tlb_ce", 64'(a_if.tlb_ce_o), 64'h1);
    chk("ct_second_vaddr", 64'(a_if.tlb_vaddr_o), (other == 0) ? 64'h3000 : 64'h4000);
    wait_any0(20, c);
    chk("ct_second_ack", 64'(a_if.ack_o), 64'(1 << other));
    chk("ct_second_lat", 64'(c), 64'd2);
    a_if.req_ce_i[other] = 1'b0;
    cyc();
    chk("ct_no_reserve_ack", 64'(a_if.ack_o), 64'h0);
    chk("ct_no_reserve_tlb", 64'(a_if.tlb_ce_o), 64'h0);

    // Full write with 5 wait states
    wait0 = 5;
    a_if.req_we_i[0] = 1'b1;
    a_if.req_addr_i[0 +: 32] = 32'h0000_5000;
    a_if.req_wdata_i[0 +: 32] = 32'hCAFE_F00D; a_if.req_sel_i[0 +: 4] = 4'hF;
    a_if.req_ce_i[0] = 1'b1;
    cyc();
    cyc();
    c = 2;
    while (a_if.ack_o == 2'b00 && c < 30) begin
      chk("ws_ce_we", 64'({a_if.bus_ce_o, a_if.bus_we_o}), 64'h3);
      chk("ws_addr", 64'(a_if.bus_addr_o), 64'h8000_5000);
      chk("ws_wdata", 64'(a_if.bus_wdata_o), 64'hCAFE_F00D);
      cyc();
      c++;
    end
    chk("ws_latency", 64'(c), 64'd8);
    chk("ws_ack", 64'(a_if.ack_o), 64'h1);
    chk("ws_ce_after", 64'(a_if.bus_ce_o), 64'h0);
    a_if.req_ce_i[0] = 1'b0;
    cyc();
    chk("ws_ack_pulse", 64'(a_if.ack_o), 64'h0);

    // Asynchronous reset in the middle of a read
    wait0 = 50;
    a_if.req_we_i[0] = 1'b0;
    a_if.req_addr_i[0 +: 32] = 32'h0000_6000;
    a_if.req_ce_i[0] = 1'b1;
    cyc();
    cyc();
    chk("ar_bus_ce_before", 64'(a_if.bus_ce_o), 64'h1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("ar_bus_ce_async", 64'(a_if.bus_ce_o), 64'h0);
    chk("ar_ack_async", 64'(a_if.ack_o), 64'h0);
    a_if.req_ce_i[0] = 1'b0;
    cyc();
    rst = 1'b0;
    wait0 = 0;
    cyc();
    cyc();
    chk("ar_idle_ack", 64'(a_if.ack_o), 64'h0);
    chk("ar_idle_ce", 64'({a_if.bus_ce_o, a_if.tlb_ce_o}), 64'h0);
    a_if.req_addr_i[0 +: 32] = 32'h0000_7000;
    a_if.bus_data_i = 32'h0BAD_F00D;
    a_if.req_ce_i[0] = 1'b1;
    wait_any0(20, c);
    chk("ar_new_latency", 64'(c), 64'd3);
    chk("ar_new_ack", 64'(a_if.ack_o), 64'h1);
    chk("ar_new_rdata", 64'(a_if.rdata_o), 64'h0BAD_F00D);
    chk("ar_new_addr", 64'(a_if.bus_addr_o), 64'h8000_7000);
    a_if.req_ce_i[0] = 1'b0;
    cyc();

    // 4-port, 64-bit: port 2 partial write with sel=0x0F
    t0 = txn1;
    b_if.req_we_i[2] = 1'b1;
    b_if.req_addr_i[64 +: 32] = 32'h0000_0100;
    b_if.req_wdata_i[128 +: 64] = 64'h0102_0304_0506_0708;
    b_if.req_sel_i[16 +: 8] = 8'h0F;
    b_if.bus_data_i = 64'hF1F2_F3F4_F5F6_F7F8;
    b_if.req_ce_i[2] = 1'b1;
    c = 0;
    do begin
      cyc();
      c++;
    end while (b_if.ack_o == 4'b0000 && c < 20);
    chk("pm_latency", 64'(c), 64'd4);
    chk("pm_ack", 64'(b_if.ack_o), 64'h4);
    chk("pm_wdata", last_wdata1, 64'hF1F2_F3F4_0506_0708);
    chk("pm_addr", 64'(b_if.bus_addr_o), 64'h8000_0100);
    chk("pm_txns", 64'(txn1 - t0), 64'd2);
    b_if.req_ce_i[2] = 1'b0;
    cyc();
    chk("pm_ack_pulse", 64'(b_if.ack_o), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
